vga_sync_receiver: RTL



---
 rtl/vga_sync_receiver.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// VGA receiver: synchronises hsync/vsync/rgb, recovers pixel coordinates, measures line/frame timing and tracks lock.
// Optional lock-loss counter on err_count is built when VGA_RX_ERR_COUNT_EN is defined.
module vga_sync_receiver #(
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int CLK_MHZ    = 50,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_DISPLAY  = 640,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_DISPLAY  = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [2:0]            rgb,
  output logic [HPOS_WIDTH-1:0] hpos,
  output logic [VPOS_WIDTH-1:0] vpos,
  output logic                  display_on,
  output logic                  pixel_valid,
  output logic [2:0]            rgb_out,
  output logic [HPOS_WIDTH-1:0] line_len,
  output logic [VPOS_WIDTH-1:0] frame_lines,
  output logic                  locked,
  output logic [7:0]            err_count
);

  localparam int PIX_DIV = CLK_MHZ / 25;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(PIX_DIV - 1);
  localparam logic [HPOS_WIDTH-1:0] H_START_C = HPOS_WIDTH'(H_SYNC + H_BACK);
  localparam logic [HPOS_WIDTH-1:0] H_END_C   = HPOS_WIDTH'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [VPOS_WIDTH-1:0] V_START_C = VPOS_WIDTH'(V_SYNC + V_BACK);
  localparam logic [VPOS_WIDTH-1:0] V_END_C   = VPOS_WIDTH'(V_SYNC + V_BACK + V_DISPLAY);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [1:0]            r_hs_sync, r_vs_sync;
  logic                  r_hs_d, r_vs_d;
  logic [2:0]            r_rgb_s1, r_rgb_s2;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [HPOS_WIDTH-1:0] r_h_cnt;
  logic [VPOS_WIDTH-1:0] r_v_cnt;
  logic                  r_h_seen, r_v_seen;
  logic [HPOS_WIDTH-1:0] r_ref_line;
  logic                  r_ref_line_vld;
  logic [VPOS_WIDTH-1:0] r_ref_frame;

  logic                  w_hfall, w_vfall, w_pix_stb, w_div_wrap;
  logic                  w_h_sat, w_v_sat;
  logic [HPOS_WIDTH-1:0] w_line_meas;
  logic [VPOS_WIDTH-1:0] w_frame_meas;
  logic                  w_line_ev, w_frame_ev, w_line_bad, w_frame_bad;
  logic                  w_enter_search, w_hvis, w_vvis, w_disp;

  // Sync flops idle high so a reset never manufactures a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_sync <= 2'b11;
      r_vs_sync <= 2'b11;
      r_hs_d    <= 1'b1;
      r_vs_d    <= 1'b1;
      r_rgb_s1  <= 3'b000;
      r_rgb_s2  <= 3'b000;
    end else begin
      r_hs_sync <= {r_hs_sync[0], hsync};
      r_vs_sync <= {r_vs_sync[0], vsync};
      r_hs_d    <= r_hs_sync[1];
      r_vs_d    <= r_vs_sync[1];
      r_rgb_s1  <= rgb;
      r_rgb_s2  <= r_rgb_s1;
    end
  end

  assign w_hfall    = r_hs_d & ~r_hs_sync[1];
  assign w_vfall    = r_vs_d & ~r_vs_sync[1];
  assign w_pix_stb  = (r_div_cnt == '0);
  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_h_sat    = &r_h_cnt;
  assign w_v_sat    = &r_v_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      if (w_hfall) begin
        r_div_cnt <= '0;
        r_h_cnt   <= '0;
      end else if (w_div_wrap) begin
        r_div_cnt <= '0;
        if (!w_h_sat) r_h_cnt <= r_h_cnt + HPOS_WIDTH'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_vfall) r_v_cnt <= '0;
      else if (w_hfall && !w_v_sat) r_v_cnt <= r_v_cnt + VPOS_WIDTH'(1);
    end
  end

  assign w_line_meas  = r_h_cnt + HPOS_WIDTH'(1);
  assign w_frame_meas = r_v_cnt + VPOS_WIDTH'(1);
  assign w_line_ev    = w_hfall & r_h_seen;
  assign w_frame_ev   = w_vfall & r_v_seen;
  assign w_line_bad   = w_line_ev & (w_line_meas != r_ref_line);
  assign w_frame_bad  = w_frame_ev & (w_frame_meas != r_ref_frame);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_SEARCH;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SEARCH:  if (w_vfall) w_state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (w_line_bad && r_ref_line_vld) w_state_next = ST_SEARCH;
        else if (w_frame_ev)              w_state_next = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (w_line_bad || w_frame_bad) w_state_next = ST_SEARCH;
        else if (w_frame_ev)           w_state_next = ST_LOCKED;
      end
      ST_LOCKED:  if (w_line_bad || w_frame_bad || w_h_sat || w_v_sat) w_state_next = ST_SEARCH;
      default:    w_state_next = ST_SEARCH;
    endcase
  end

  assign w_enter_search = (w_state_next == ST_SEARCH) && (r_state != ST_SEARCH);

  // Partial periods after reset or lock loss must not be reported as measurements.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_seen <= 1'b0;
      r_v_seen <= 1'b0;
    end else if (w_enter_search) begin
      r_h_seen <= 1'b0;
      r_v_seen <= 1'b0;
    end else begin
      if (w_hfall) r_h_seen <= 1'b1;
      if (w_vfall) r_v_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      if (w_line_ev)  line_len    <= w_line_meas;
      if (w_frame_ev) frame_lines <= w_frame_meas;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ref_line     <= '0;
      r_ref_line_vld <= 1'b0;
      r_ref_frame    <= '0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          r_ref_line     <= '0;
          r_ref_line_vld <= 1'b0;
          r_ref_frame    <= '0;
        end
        ST_MEASURE: begin
          if (w_line_ev && !r_ref_line_vld) begin
            r_ref_line     <= w_line_meas;
            r_ref_line_vld <= 1'b1;
          end
          if (w_state_next == ST_CONFIRM) r_ref_frame <= w_frame_meas;
        end
        default: ;
      endcase
    end
  end

  assign locked = (r_state == ST_LOCKED);
  assign w_hvis = (r_h_cnt >= H_START_C) && (r_h_cnt < H_END_C);
  assign w_vvis = (r_v_cnt >= V_START_C) && (r_v_cnt < V_END_C);
  assign w_disp = w_hvis & w_vvis & locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_on  <= 1'b0;
      pixel_valid <= 1'b0;
      rgb_out     <= 3'b000;
      hpos        <= '0;
      vpos        <= '0;
    end else begin
      display_on  <= w_disp;
      pixel_valid <= w_disp & w_pix_stb;
      if (w_disp && w_pix_stb) rgb_out <= r_rgb_s2;
      hpos        <= w_disp ? (r_h_cnt - H_START_C) : '0;
      vpos        <= w_disp ? (r_v_cnt - V_START_C) : '0;
    end
  end

`ifdef VGA_RX_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err_count <= 8'd0;
    else if (locked && (w_state_next == ST_SEARCH) && (r_err_count != 8'hff))
      r_err_count <= r_err_count + 8'd1;
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule
